// File: rtl/alu_defs.sv
// Shared ALU definitions: opcodes, sequencer states, CCR bit positions and
// small opcode classification helpers used by the sequencer and the ALU.
package alu_defs;

    typedef enum logic [3:0] {
        OP_INC  = 4'd0,
        OP_DEC  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_NOT  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_MOV  = 4'd9,
        OP_SETC = 4'd10,
        OP_CLC  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    localparam int unsigned CCR_W = 3;
    localparam int unsigned CCR_C = 2;
    localparam int unsigned CCR_N = 1;
    localparam int unsigned CCR_Z = 0;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic op_defined(input logic [3:0] op);
        return op <= OP_CLC;
    endfunction

    // SETC/CLC only touch flags; undefined opcodes produce nothing useful.
    function automatic logic op_writes_back(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Issue/result handshake bundle between an instruction source and the sequencer.
interface alu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [CNT_W-1:0]  in_shamt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_wb;

    modport master (
        output in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        input  in_ready, out_valid, out_result, out_wb
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        output in_ready, out_valid, out_result, out_wb
    );
endinterface

// File: rtl/alu_ccr_reg.sv
// Condition-code register {C,N,Z} with per-opcode update masking.
module alu_ccr_reg
    import alu_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [3:0]       op,
    input  logic             c_hold,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             res_msb,
    output logic [CCR_W-1:0] ccr
);
    logic [CCR_W-1:0] ccr_q;
    logic [CCR_W-1:0] ccr_n;

    // Select which flags the committing opcode is allowed to change.
    always_comb begin
        ccr_n = ccr_q;
        if (upd) begin
            case (op)
                OP_INC, OP_ADD: begin
                    ccr_n[CCR_C] = alu_c;
                    ccr_n[CCR_N] = res_msb;
                    ccr_n[CCR_Z] = alu_z;
                end
                OP_DEC, OP_SUB: begin
                    ccr_n[CCR_C] = alu_n;
                    ccr_n[CCR_N] = res_msb;
                    ccr_n[CCR_Z] = alu_z;
                end
                OP_NOT, OP_AND, OP_OR: begin
                    ccr_n[CCR_N] = res_msb;
                    ccr_n[CCR_Z] = alu_z;
                end
                OP_SHL, OP_SHR: begin
                    // A zero-length shift shifts nothing out, so C is kept.
                    if (!c_hold) ccr_n[CCR_C] = alu_c;
                    ccr_n[CCR_N] = res_msb;
                    ccr_n[CCR_Z] = alu_z;
                end
                OP_SETC: ccr_n[CCR_C] = 1'b1;
                OP_CLC:  ccr_n[CCR_C] = 1'b0;
                default: ccr_n = ccr_q;
            endcase
        end
    end

    // Flag storage.
    always_ff @(posedge clk) begin
        if (rst) ccr_q <= '0;
        else     ccr_q <= ccr_n;
    end

    assign ccr = ccr_q;
endmodule

// File: rtl/alu_sequencer.sv
// Issues one operation at a time to an external ALU; multi-bit shifts are
// sequenced as repeated single-bit steps through the same ALU.
module alu_sequencer
    import alu_defs::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    bus,
    input  logic              flush,
    output logic              alu_en,
    output logic [3:0]        alu_func,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CNT_W-1:0]  alu_shamt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic [CCR_W-1:0]  ccr
);
    seq_state_e        state, state_n;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, work_q, result_q;
    logic [CNT_W-1:0]  shamt_q, cnt_q;
    logic              wb_q;
    logic              capture, accept, commit, c_hold;

    assign accept  = (state == ST_IDLE) && !flush && bus.in_valid;
    assign commit  = capture && !flush;
    assign c_hold  = (state == ST_EXEC) && is_shift(op_q);

    assign bus.in_ready   = (state == ST_IDLE) && !flush;
    assign bus.out_valid  = (state == ST_HOLD);
    assign bus.out_result = result_q;
    assign bus.out_wb     = wb_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state decode and ALU command drive.
    always_comb begin
        state_n   = state;
        alu_en    = 1'b0;
        alu_func  = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_n = (is_shift(bus.in_op) && bus.in_shamt != '0) ? ST_SHIFT : ST_EXEC;
            end
            ST_EXEC: begin
                alu_en    = op_defined(op_q);
                alu_func  = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                alu_shamt = shamt_q;
                capture   = 1'b1;
                state_n   = flush ? ST_IDLE : ST_HOLD;
            end
            ST_SHIFT: begin
                alu_en    = 1'b1;
                alu_func  = op_q;
                alu_a     = work_q;
                alu_b     = b_q;
                alu_shamt = CNT_W'(1);
                if (flush) begin
                    state_n = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush || bus.out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand latch, shift working register/step counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            wb_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.in_op;
                a_q     <= bus.in_a;
                b_q     <= bus.in_b;
                shamt_q <= bus.in_shamt;
                work_q  <= bus.in_a;
                cnt_q   <= bus.in_shamt;
            end
            if (state == ST_SHIFT && !flush) begin
                work_q <= alu_out;
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            if (commit) begin
                result_q <= alu_out;
                wb_q     <= op_writes_back(op_q);
            end
        end
    end

    alu_ccr_reg u_ccr (
        .clk     (clk),
        .rst     (rst),
        .upd     (commit),
        .op      (op_q),
        .c_hold  (c_hold),
        .alu_c   (alu_c),
        .alu_n   (alu_n),
        .alu_z   (alu_z),
        .res_msb (alu_out[DATA_W-1]),
        .ccr     (ccr)
    );
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, transaction-level reference model
// and an in-order scoreboard of expected results.
module tb_alu_sequencer;
    import alu_defs::*;

    typedef struct {
        logic [15:0] res;
        logic        chk_res;
        logic        wb;
        logic [2:0]  ccr;
        int          lat;
        int          en;
        logic        step;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alu_en;
    logic [3:0]  alu_func;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_shamt;
    logic        alu_c, alu_n, alu_z;
    logic [2:0]  ccr;
    logic [16:0] alu_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_edge = 0;
    int   hs_edge  = 0;
    int   rel_edge = 0;
    int   en_cnt   = 0;
    int   sh1_cnt  = 0;
    bit   seen     = 0;
    exp_t cur;
    exp_t sb[$];
    logic [2:0] model_ccr;

    alu_sequencer_if #(.DATA_W(16), .CNT_W(4)) bus ();

    alu_sequencer #(.DATA_W(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .flush     (flush),
        .alu_en    (alu_en),
        .alu_func  (alu_func),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shamt (alu_shamt),
        .alu_out   (alu_out),
        .alu_c     (alu_c),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .ccr       (ccr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ALU model: combinational, C in bit 16 of alu_t.
    always_comb begin
        alu_t = '0;
        case (alu_func)
            OP_INC:  alu_t = {1'b0, alu_a} + 17'd1;
            OP_DEC:  alu_t = {1'b0, alu_a} - 17'd1;
            OP_ADD:  alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            OP_NOT:  alu_t = {1'b0, ~alu_a};
            OP_AND:  alu_t = {1'b0, alu_a & alu_b};
            OP_OR:   alu_t = {1'b0, alu_a | alu_b};
            OP_SHL:  alu_t = {1'b0, alu_a} << alu_shamt;
            OP_SHR: begin
                alu_t[15:0] = alu_a >> alu_shamt;
                if (alu_shamt != 4'd0) alu_t[16] = alu_a[int'(alu_shamt) - 1];
            end
            OP_MOV:  alu_t = {1'b0, alu_a};
            default: alu_t = '0;
        endcase
        alu_out = alu_t[15:0];
        alu_c   = alu_t[16];
        alu_n   = alu_out[15];
        alu_z   = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Whole-operation reference: shifts done in one step, flags per opcode.
    task automatic model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] sh, output exp_t e);
        logic [16:0] full;
        logic [15:0] r;
        logic        c;
        bit          upd_nz, upd_c;
        int          s;
        s = int'(sh);
        full = '0; r = '0; c = model_ccr[2]; upd_nz = 1; upd_c = 0;
        case (op)
            OP_INC: begin full = {1'b0, a} + 17'd1; r = full[15:0]; c = full[16]; upd_c = 1; end
            OP_DEC: begin r = a - 16'd1; c = r[15]; upd_c = 1; end
            OP_ADD: begin full = {1'b0, a} + {1'b0, b}; r = full[15:0]; c = full[16]; upd_c = 1; end
            OP_SUB: begin r = a - b; c = r[15]; upd_c = 1; end
            OP_NOT: r = ~a;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SHL: begin r = a << s; if (s > 0) begin c = a[16 - s]; upd_c = 1; end end
            OP_SHR: begin r = a >> s; if (s > 0) begin c = a[s - 1]; upd_c = 1; end end
            OP_MOV: begin r = a; upd_nz = 0; end
            OP_SETC: begin upd_nz = 0; c = 1'b1; upd_c = 1; end
            OP_CLC:  begin upd_nz = 0; c = 1'b0; upd_c = 1; end
            default: upd_nz = 0;
        endcase
        if (upd_nz) begin model_ccr[1] = r[15]; model_ccr[0] = (r == 16'h0000); end
        if (upd_c) model_ccr[2] = c;
        e.res     = r;
        e.chk_res = (op <= 4'd9);
        e.wb      = (op <= 4'd9);
        e.ccr     = model_ccr;
        e.step    = (op == OP_SHL || op == OP_SHR) && s > 0;
        e.lat     = e.step ? s + 1 : 2;
        e.en      = e.step ? s : ((op <= 4'd11) ? 1 : 0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, input bit track);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_shamt = sh;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        if (!got) check("issue_timeout", 32'(bus.in_ready), 1);
        else if (track) begin
            model_op(op, a, b, sh, e);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) done = 1;
        end
        if (!done) begin
            check("done_timeout_pending", 32'(sb.size()), 0);
            check("done_timeout_valid", 32'(bus.out_valid), 0);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh);
        issue(op, a, b, sh, 1);
        wait_done();
    endtask

    // Output monitor: ALU activity counting, scoreboard pop and hold stability.
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else begin
            if (alu_en) begin
                en_cnt++;
                if (alu_shamt == 4'd1) sh1_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_edge = cyc + 1;
                en_cnt   = 0;
                sh1_cnt  = 0;
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        check("out_valid_unexpected", 32'(bus.out_valid), 0);
                        cur.chk_res = 0;
                        cur.wb      = bus.out_wb;
                    end else begin
                        cur = sb.pop_front();
                        if (cur.chk_res) check("result", 32'(bus.out_result), 32'(cur.res));
                        check("wb", 32'(bus.out_wb), 32'(cur.wb));
                        check("ccr", 32'(ccr), 32'(cur.ccr));
                        check("latency", cyc + 1 - acc_edge, cur.lat);
                        check("alu_en_cycles", en_cnt, cur.en);
                        if (cur.step) check("alu_shamt_one_cycles", sh1_cnt, cur.en);
                    end
                end else begin
                    if (cur.chk_res) check("hold_result", 32'(bus.out_result), 32'(cur.res));
                    check("hold_wb", 32'(bus.out_wb), 32'(cur.wb));
                end
                if (bus.out_ready) begin
                    seen    = 0;
                    hs_edge = cyc + 1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_shamt = '0; bus.out_ready = 1'b1;
        model_ccr = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_result", 32'(bus.out_result), 0);
        check("rst_out_wb", 32'(bus.out_wb), 0);
        check("rst_ccr", 32'(ccr), 0);
        check("rst_alu_en", 32'(alu_en), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        run(OP_ADD, 16'hFFFF, 16'h0001, 4'd0);
        run(OP_SHL, 16'h1000, 16'h0000, 4'd4);
        run(OP_SUB, 16'h0003, 16'h0005, 4'd0);

        // Flush on the capture edge: no result, flags untouched.
        issue(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_exec_ccr", 32'(ccr), 32'(model_ccr));
        check("flush_exec_valid", 32'(bus.out_valid), 0);
        check("flush_exec_alu_en", 32'(alu_en), 0);

        run(OP_CLC, 16'h1234, 16'h0000, 4'd0);
        run(OP_SETC, 16'h1234, 16'h0000, 4'd0);
        run(OP_MOV, 16'h0000, 16'h0000, 4'd0);
        run(OP_SHL, 16'h8001, 16'h0000, 4'd0);
        run(OP_SHR, 16'h0003, 16'h0000, 4'd1);
        run(OP_SHR, 16'h8000, 16'h0000, 4'd15);
        run(OP_INC, 16'hFFFF, 16'h0000, 4'd0);
        run(OP_DEC, 16'h0000, 16'h0000, 4'd0);
        run(OP_SUB, 16'hFFFF, 16'h0001, 4'd0);
        run(OP_NOT, 16'h00FF, 16'h0000, 4'd0);
        run(OP_AND, 16'hF0F0, 16'hFF00, 4'd0);
        run(OP_OR,  16'h0000, 16'h0000, 4'd0);
        run(4'd13,  16'h5555, 16'hAAAA, 4'd0);

        // Back-pressure in HOLD with a second request already pending.
        bus.out_ready = 1'b0;
        fork
            begin
                issue(OP_ADD, 16'h0001, 16'h0002, 4'd0, 1);
                issue(OP_INC, 16'h0041, 16'h0000, 4'd0, 1);
            end
            begin
                bit vis;
                vis = 0;
                for (int i = 0; i < 20 && !vis; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) vis = 1;
                end
                if (!vis) check("stall_valid_timeout", 32'(bus.out_valid), 1);
                for (int j = 0; j < 3; j++) begin
                    if (j > 0) @(negedge clk);
                    check("stall_in_ready", 32'(bus.in_ready), 0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                rel_edge = cyc + 1;
            end
        join
        check("stall_release_edge", hs_edge, rel_edge);
        check("accept_after_release", acc_edge, rel_edge + 1);
        wait_done();

        // Flush a long shift partway through.
        issue(OP_SHR, 16'hABCD, 16'h0000, 4'd8, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_shift_in_ready", 32'(bus.in_ready), 1);
        check("flush_shift_valid", 32'(bus.out_valid), 0);
        check("flush_shift_alu_en", 32'(alu_en), 0);
        check("flush_shift_ccr", 32'(ccr), 32'(model_ccr));
        repeat (12) @(negedge clk);

        // Reset mid-shift, asserted together with flush.
        issue(OP_SHR, 16'hFFFF, 16'h0000, 4'd8, 0);
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        model_ccr = 3'b000;
        @(negedge clk);
        check("midrst_ccr", 32'(ccr), 0);
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        repeat (12) @(negedge clk);
        run(OP_ADD, 16'h7FFF, 16'h0001, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: DATA_W, 16, operand/result width (must equal ALU width).
REQ-002 SHALL have parameter: CNT_W, 4, shift-amount/step-counter width.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_valid/in_ready  input/output  1/1  issue handshake.
REQ-006 SHALL have ports: in_op  input  4  ALU opcode (INC=0 ... CLC=11; 12-15 undefined).
REQ-007 SHALL have ports: in_a, in_b  input  DATA_W  operands; in_shamt  input  CNT_W  shift amount.
REQ-008 SHALL have ports: alu_en  output  1; alu_func  output  4; alu_a, alu_b  output  DATA_W; alu_shamt  output  CNT_W.
REQ-009 SHALL have ports: alu_out  input  DATA_W; alu_c, alu_n, alu_z  input  1  ALU result/flags.
REQ-010 SHALL have ports: out_valid  output  1; out_ready  input  1; out_result  output  DATA_W; out_wb  output  1  result is writeback-worthy.
REQ-011 SHALL have ports: ccr  output  3  {C,N,Z}; flush  input  1  discard in-flight op.

Function
REQ-012 SHALL implement FSM IDLE, EXEC, SHIFT, HOLD; in_ready=1 only in IDLE with flush=0.
REQ-013 SHALL, on in_valid&in_ready, latch op/operands/shamt and go to SHIFT if op is SHL/SHR with shamt>0, else EXEC.
REQ-014 SHALL in EXEC drive alu_en=1 (0 for undefined opcodes), alu_func=op, alu_a/alu_b=latched operands for exactly one cycle, capture result, go HOLD.
REQ-015 SHALL in SHIFT drive alu_shamt=1, alu_a=working register (initialised to in_a), load working register from alu_out each cycle, decrement step counter, leave after shamt cycles for HOLD.
REQ-016 SHALL, for a shift, take C from alu_c of the final step (last bit shifted out).
REQ-017 SHALL treat SHL/SHR with shamt=0 as one EXEC cycle returning in_a, C unchanged.
REQ-018 SHALL assert out_valid from the cycle after the last ALU cycle: latency 2 cycles from accepting edge for non-shifts, shamt+1 for shifts>0.
REQ-019 SHALL hold out_valid, out_result, out_wb stable in HOLD until out_ready=1, then return to IDLE; no accept in the same cycle.
REQ-020 SHALL drive alu_en=0, alu_func=0 in IDLE and HOLD.
REQ-021 SHALL update ccr on the edge the result is captured: Z=alu_z, N=result[15] for INC/DEC/ADD/SUB/NOT/AND/OR/SHL/SHR; C=alu_c for INC/ADD/SHL/SHR; C=alu_n (borrow) for SUB/DEC; C=1 SETC; C=0 CLC; MOV and undefined leave ccr unchanged.
REQ-022 SHALL set out_wb=0 for SETC, CLC, undefined opcodes; 1 otherwise.
REQ-023 SHALL, on flush in any state, go to IDLE next edge, deassert out_valid, leave ccr at prior value for the flushed op (flush on capture edge suppresses ccr update).

Reset
REQ-024 SHALL on rst: state=IDLE, ccr=3'b000, out_valid=0, out_result=0, out_wb=0, working register and counter=0, alu_en=0.
REQ-025 SHALL, on rst mid-EXEC/SHIFT/HOLD, abandon the op with no ccr update; rst has priority over flush.

Structure
REQ-026 SHALL place opcode constants, FSM state encodings and CCR bit indices in shared package alu_defs, reused by the ALU.
REQ-027 SHALL implement flag storage and update-mask logic as sub-module alu_ccr_reg; ALU instantiated outside this block.

Verification
REQ-028 SHALL cover ADD 0xFFFF+0x0001 -> out_result 0x0000, ccr C=1,N=0,Z=1, out_valid 2 cycles after accept, out_wb=1.
REQ-029 SHALL cover SHL a=0x1000 shamt=4 -> 4 alu_en cycles with alu_shamt=1, out_result 0x0000, C=1, Z=1, latency 5.
REQ-030 SHALL cover SUB 0x0003-0x0005 -> out_result 0xFFFE, C=1, N=1, Z=0.
REQ-031 SHALL cover out_ready low 3 cycles in HOLD -> result stable, in_ready=0, pending in_valid not accepted until cycle after release.
REQ-032 SHALL cover SHR shamt=8 with flush at step 3 -> IDLE next cycle, out_valid never asserted, ccr unchanged.
REQ-033 SHALL cover SETC then MOV a=0x0000 -> ccr C=1 after SETC with out_wb=0; MOV leaves ccr unchanged.
